fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 4, number of write requesters (2..8).
REQ-002 Parameter B, default 8, data width; matches the FIFO data width.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (1..15).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N  per-requester write request; bit i holds while requester i has a beat to write.
REQ-007 req_data  input  N*B  flattened data; slice i = bits [i*B+B-1 : i*B].
REQ-008 fifo_full  input  1  full flag from the shared FIFO.
REQ-009 fifo_wr  output  1  write strobe to the FIFO.
REQ-010 fifo_w_data  output  B  write data to the FIFO.
REQ-011 gnt  output  N  one-hot beat acknowledge; gnt[i]=1 means slice i was written this cycle.
REQ-012 busy  output  1  high while a burst is owned.
REQ-013 owner  output  3  index of the current or last burst owner.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE, if req is nonzero and fifo_full=0, the block SHALL select a winner round-robin, starting the search at pointer rr_ptr and wrapping modulo N.
REQ-016 On selection, the block SHALL load owner with the winner, clear beat_cnt and enter BURST on the next edge; IDLE never writes, so arbitration costs one bubble cycle.
REQ-017 In BURST, a beat SHALL occur when req[owner]=1 and fifo_full=0.
REQ-018 During a beat, fifo_wr=1, gnt=one-hot(owner) and fifo_w_data=slice owner, all combinational in the same cycle.
REQ-019 Outside a beat, fifo_wr=0 and gnt=0, and fifo_w_data SHALL hold slice owner (don't-care to the FIFO).
REQ-020 Each beat SHALL increment beat_cnt (4 bits).
REQ-021 The block SHALL return to IDLE and set rr_ptr to (owner+1) mod N when either condition holds:
  - a beat occurs with beat_cnt = MAX_BURST-1;
  - req[owner]=0 in BURST (no beat that cycle).
REQ-022 fifo_full=1 in BURST SHALL stall: no beat, beat_cnt holds, ownership retained; there is no timeout.
REQ-023 fifo_full=1 in IDLE SHALL block selection; state and rr_ptr hold.
REQ-024 At most one gnt bit SHALL be high in any cycle, and gnt SHALL never be high while fifo_full=1.
REQ-025 Requests from non-owners SHALL be ignored until the owner releases.
REQ-026 busy SHALL equal (state==BURST).
REQ-027 Worst-case wait for a requester holding req SHALL be (N-1)*(MAX_BURST+1) non-full cycles before its burst starts.

Reset
REQ-028 Asserting reset SHALL immediately force: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0; hence fifo_wr=0, gnt=0, busy=0, fifo_w_data=slice 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; no beat occurs while reset is low, and rr_ptr restarts at 0.
REQ-030 After reset deasserts, the first selection SHALL occur at the first posedge with req nonzero and fifo_full=0.

Structure
REQ-031 Shared package fifo_arb_pkg SHALL hold the state enumeration (IDLE=0, BURST=1), the beat_cnt width constant (4) and the owner width constant (3).
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, rr_ptr; outputs valid, idx), instantiated once.
REQ-033 The FIFO itself is outside this block; fifo_wr and fifo_w_data connect directly to its wr and w_data ports, and the block does not drive rd.

Verification
REQ-034 Single requester: req=4'b0010, data1=8'hA5, fifo not full -> busy from cycle 2; gnt=4'b0010 and fifo_wr=1 for 4 beats writing A5; then one IDLE cycle; rr_ptr=2.
REQ-035 All requesting: req=4'b1111 held, MAX_BURST=4 -> bursts granted in order 0,1,2,3,0; each burst is 4 beats separated by one idle cycle; no double gnt.
REQ-036 Full stall: fifo_full=1 after beat 2 of owner 0 for 3 cycles -> fifo_wr=0 for those cycles, owner stays 0, beats 3-4 resume after full drops, total 4 beats.
REQ-037 Early release: owner 2 drops req after 1 beat -> next cycle IDLE, rr_ptr=3; pending req[0] wins only if req[3]=0.
REQ-038 Reset mid-burst: reset low during beat 2 of owner 3 -> fifo_wr=0, gnt=0, busy=0 immediately; after release with req=4'b1001, owner 0 wins.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// widths of the beat counter and the owner index.
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int CNT_W   = 4;   // beat_cnt width
    localparam int OWNER_W = 3;   // owner / rr_ptr width (up to 8 requesters)

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester side and the FIFO write side of the arbiter.
//   req, req_data, fifo_full : driven by requesters / FIFO   (into arbiter)
//   fifo_wr, fifo_w_data     : FIFO write strobe and data   (from arbiter)
//   gnt                      : one-hot beat acknowledge     (from arbiter)
//   busy, owner              : burst status                 (from arbiter)
// Modports: slave = arbiter side, master = requesters/FIFO side.
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int N = 4,
    parameter int B = 8
);
    import fifo_arb_pkg::*;

    logic [N-1:0]       req;
    logic [N*B-1:0]     req_data;
    logic               fifo_full;
    logic               fifo_wr;
    logic [B-1:0]       fifo_w_data;
    logic [N-1:0]       gnt;
    logic               busy;
    logic [OWNER_W-1:0] owner;

    modport master (
        output req, req_data, fifo_full,
        input  fifo_wr, fifo_w_data, gnt, busy, owner
    );

    modport slave (
        input  req, req_data, fifo_full,
        output fifo_wr, fifo_w_data, gnt, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting at rr_ptr_i and
// wrapping modulo N; returns the first set index.
//   req_i    : request vector
//   rr_ptr_i : index where the search starts
//   valid_o  : some request is set
//   idx_o    : winning index (0 when valid_o is low)
// ----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req_i,
    input  logic [OWNER_W-1:0] rr_ptr_i,
    output logic               valid_o,
    output logic [OWNER_W-1:0] idx_o
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(rr_ptr_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = OWNER_W'((int'(rr_ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Grants N write requesters bursts of up to MAX_BURST beats into one shared
// FIFO, round-robin. IDLE picks a winner (one bubble cycle), BURST writes one
// beat per cycle while the owner requests and the FIFO is not full.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if.slave (req/req_data/fifo_full in,
//           fifo_wr/fifo_w_data/gnt/busy/owner out)
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int B         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus
);

    arb_state_e         state_q;
    logic [OWNER_W-1:0] owner_q;
    logic [OWNER_W-1:0] rr_ptr_q;
    logic [OWNER_W-1:0] rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic [N-1:0]       owner_oh;
    logic               owner_req;
    logic               beat;
    logic               last_beat;
    logic [B-1:0]       w_data;

    rr_pick #(.N(N)) u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

    // One-hot owner avoids an out-of-range bit select when N < 8.
    assign owner_oh  = N'(1) << owner_q;
    assign owner_req = |(bus.req & owner_oh);
    assign beat      = (state_q == BURST) && owner_req && !bus.fifo_full;
    assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    assign rr_ptr_d  = (owner_q == OWNER_W'(N - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid && !bus.fifo_full) begin
                        owner_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        if (last_beat) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end else if (!owner_req) begin
                        // Owner released early; a full FIFO alone just stalls.
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data always follows the owner slice, whether or not a beat occurs.
    always_comb begin
        w_data = bus.req_data[B-1:0];
        for (int i = 0; i < N; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                w_data = bus.req_data[i*B +: B];
            end
        end
    end

    assign bus.fifo_wr     = beat;
    assign bus.gnt         = beat ? owner_oh : '0;
    assign bus.fifo_w_data = w_data;
    assign bus.busy        = (state_q == BURST);
    assign bus.owner       = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Scoreboard bench for fifo_wr_arbiter (N=4, B=8, MAX_BURST=4). The driver
// predicts each cycle's outputs from a behavioural model and queues them; a
// monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int B  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .B(B)) arb_if ();

    fifo_wr_arbiter #(.N(N), .B(B), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (arb_if)
    );

    typedef struct {
        logic         wr;
        logic [N-1:0] gnt;
        logic [B-1:0] data;
        logic         busy;
        logic [2:0]   owner;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: who owns the FIFO, how many beats it has written,
    // and where the next round-robin search starts.
    bit   m_busy;
    int   m_owner;
    int   m_beats;
    int   m_ptr;
    logic [B-1:0] slice [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*B-1:0] flat_data();
        logic [N*B-1:0] f;
        for (int i = 0; i < N; i++) f[i*B +: B] = slice[i];
        return f;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
    endtask

    // One clock cycle of stimulus plus its predicted outputs.
    task automatic drive(input logic [N-1:0] r, input bit f);
        exp_t e;
        @(posedge clk);
        #1;
        arb_if.req       = r;
        arb_if.req_data  = flat_data();
        arb_if.fifo_full = f;
        e.busy  = m_busy;
        e.owner = 3'(m_owner);
        e.data  = slice[m_owner];
        e.wr    = 1'b0;
        e.gnt   = '0;
        if (!m_busy) begin
            if (r != 0 && !f) begin
                for (int k = 0; k < N; k++) begin
                    if (r[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_busy  = 1;
                m_beats = 0;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (!f) begin
            e.wr  = 1'b1;
            e.gnt = N'(1) << m_owner;
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        sb.push_back(e);
    endtask

    // Assert reset asynchronously, check outputs drop at once, hold, release.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_fifo_wr", 32'(arb_if.fifo_wr), 0);
        chk("rst_gnt",     32'(arb_if.gnt), 0);
        chk("rst_busy",    32'(arb_if.busy), 0);
        chk("rst_owner",   32'(arb_if.owner), 0);
        chk("rst_data",    32'(arb_if.fifo_w_data), 32'(slice[0]));
        arb_if.req       = '0;
        arb_if.fifo_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                chk("inrst_fifo_wr", 32'(arb_if.fifo_wr), 0);
                chk("inrst_busy",    32'(arb_if.busy), 0);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fifo_wr", 32'(arb_if.fifo_wr),     32'(e.wr));
                chk("gnt",     32'(arb_if.gnt),         32'(e.gnt));
                chk("data",    32'(arb_if.fifo_w_data), 32'(e.data));
                chk("busy",    32'(arb_if.busy),        32'(e.busy));
                chk("owner",   32'(arb_if.owner),       32'(e.owner));
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        bit           f;
        for (int i = 0; i < N; i++) slice[i] = 8'($urandom);
        reset            = 1'b0;
        arb_if.req       = '0;
        arb_if.req_data  = flat_data();
        arb_if.fifo_full = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;

        // Single requester 1 writing A5
        slice[1] = 8'hA5;
        repeat (7) drive(4'b0010, 1'b0);
        repeat (2) drive(4'b0000, 1'b0);

        // All requesting from a fresh pointer: order 0,1,2,3,0
        pulse_reset();
        repeat (26) drive(4'b1111, 1'b0);

        // Full stall after beat 2 of owner 0
        pulse_reset();
        repeat (3) drive(4'b0001, 1'b0);
        repeat (3) drive(4'b0001, 1'b1);
        repeat (3) drive(4'b0001, 1'b0);
        drive(4'b0000, 1'b0);

        // Early release by owner 2, then req[0] only
        pulse_reset();
        repeat (2) drive(4'b0100, 1'b0);
        repeat (3) drive(4'b0001, 1'b0);

        // Early release by owner 2, then req[3] and req[0]: 3 wins
        pulse_reset();
        repeat (2) drive(4'b0100, 1'b0);
        repeat (3) drive(4'b1001, 1'b0);

        // Reset during beat 2 of owner 3, then 4'b1001 -> owner 0
        pulse_reset();
        repeat (2) drive(4'b1000, 1'b0);
        pulse_reset();
        repeat (4) drive(4'b1001, 1'b0);

        // Randomized traffic
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
            f = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) slice[i] = 8'($urandom);
            drive(r, f);
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
